// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command channel into the ALU sequencer.
// Carries one register-register or register-immediate ALU command over a
// valid/ready handshake.
//   valid   : command present (master -> slave)
//   ready   : sequencer can accept a command (slave -> master)
//   op      : ALU func code
//   rd      : destination register index
//   rs1     : source register index for operand a
//   rs2     : source register index for operand b (ignored when use_imm = 1)
//   use_imm : 1 selects imm as operand b instead of R[rs2]
//   imm     : immediate operand
interface alu_sequencer_if;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned AW     = 3;
    localparam int unsigned OP_W   = 4;

    logic            valid;
    logic            ready;
    logic [OP_W-1:0] op;
    logic [AW-1:0]   rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            use_imm;
    logic [XLEN-1:0] imm;

    // Command source side
    modport master (
        output valid, op, rd, rs1, rs2, use_imm, imm,
        input  ready
    );

    // Sequencer side
    modport slave (
        input  valid, op, rd, rs1, rs2, use_imm, imm,
        output ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side initiator for an external combinational ALU.
// Accepts a command, reads operands from an 8x32 register file, presents
// them to the ALU for a full cycle, captures the result and writes it back.
// One command every 4 cycles: IDLE -> EXEC -> CAPT -> WB -> IDLE.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   cmd         : command channel (slave modport of alu_sequencer_if)
//   alu_a/b     : registered ALU operands
//   alu_func    : registered ALU opcode
//   alu_res     : ALU result
//   alu_zero    : ALU zero flag
//   done        : one-cycle pulse while the command is in writeback
//   zero_flag   : alu_zero of the last command that completed without fault
//   err_div0    : sticky, DIV/MOD with operand b = 0
//   err_illegal : sticky, opcode outside the defined set
//   err_clr     : clears both sticky errors (a same-cycle set wins)
//   dbg_addr    : debug read address
//   dbg_data    : combinational read of R[dbg_addr]
module alu_sequencer (
    input  logic                 clk,
    input  logic                 rst,
    alu_sequencer_if.slave       cmd,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [3:0]           alu_func,
    input  logic [31:0]          alu_res,
    input  logic                 alu_zero,
    output logic                 done,
    output logic                 zero_flag,
    output logic                 err_div0,
    output logic                 err_illegal,
    input  logic                 err_clr,
    input  logic [2:0]           dbg_addr,
    output logic [31:0]          dbg_data
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 3;
    localparam int unsigned NREGS = 8;
    localparam int unsigned OP_W  = 4;

    // ALU opcode encodings
    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV  = 4'd3;
    localparam logic [OP_W-1:0] OP_MOD  = 4'd4;
    localparam logic [OP_W-1:0] OP_AND  = 4'd5;
    localparam logic [OP_W-1:0] OP_OR   = 4'd6;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd7;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd8;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd9;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd10;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd11;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] regs [NREGS];
    logic [AW-1:0]   rd_q;
    logic [XLEN-1:0] res_q;
    logic            zero_q;
    logic            div0_q;
    logic            ill_q;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            is_div;
    logic            is_legal;

    // Register 0 reads as zero regardless of storage contents
    assign rs1_val  = (cmd.rs1  == AW'(0)) ? XLEN'(0) : regs[cmd.rs1];
    assign rs2_val  = (cmd.rs2  == AW'(0)) ? XLEN'(0) : regs[cmd.rs2];
    assign dbg_data = (dbg_addr == AW'(0)) ? XLEN'(0) : regs[dbg_addr];

    // Fault classification of the opcode currently driven to the ALU
    assign is_div   = (alu_func == OP_DIV) || (alu_func == OP_MOD);
    assign is_legal = (alu_func <= OP_SLTU);

    // Sequencer FSM, register file and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd.ready   <= 1'b1;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_func    <= OP_ADD;
            rd_q        <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            div0_q      <= 1'b0;
            ill_q       <= 1'b0;
            done        <= 1'b0;
            zero_flag   <= 1'b0;
            err_div0    <= 1'b0;
            err_illegal <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;

            // Clear first; a set in WB below overrides it in the same cycle
            if (err_clr) begin
                err_div0    <= 1'b0;
                err_illegal <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cmd.valid && cmd.ready) begin
                        rd_q      <= cmd.rd;
                        alu_a     <= rs1_val;
                        alu_b     <= cmd.use_imm ? cmd.imm : rs2_val;
                        alu_func  <= cmd.op;
                        cmd.ready <= 1'b0;
                        state     <= EXEC;
                    end
                end

                // Operands settle through the ALU for this whole cycle
                EXEC: begin
                    div0_q <= is_div && (alu_b == XLEN'(0));
                    ill_q  <= !is_legal;
                    state  <= CAPT;
                end

                // done is registered here so it is high throughout WB
                CAPT: begin
                    res_q  <= alu_res;
                    zero_q <= alu_zero;
                    done   <= 1'b1;
                    state  <= WB;
                end

                WB: begin
                    if (div0_q || ill_q) begin
                        if (div0_q) begin
                            err_div0 <= 1'b1;
                        end
                        if (ill_q) begin
                            err_illegal <= 1'b1;
                        end
                    end else begin
                        zero_flag <= zero_q;
                        if (rd_q != AW'(0)) begin
                            regs[rd_q] <= res_q;
                        end
                    end
                    cmd.ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    cmd.ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer.
// Plays the external combinational ALU, drives commands, keeps a register
// and flag model, and compares each completion against a scoreboard entry.
module tb_alu_sequencer;
    localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  MUL = 4'd2,  DIV = 4'd3;
    localparam logic [3:0] MOD = 4'd4,  AND_ = 4'd5, OR_ = 4'd6,  XOR_ = 4'd7;
    localparam logic [3:0] NOT_ = 4'd8, SHL = 4'd9,  SHR = 4'd10, SLT = 4'd11;
    localparam logic [3:0] SLTU = 4'd12;

    typedef struct {
        logic [2:0]  rd;
        logic        zf;
        logic        ediv;
        logic        eill;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_func;
    logic        alu_zero;
    logic        done, zero_flag, err_div0, err_illegal, err_clr;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    alu_sequencer_if cmd ();

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_func    (alu_func),
        .alu_res     (alu_res),
        .alu_zero    (alu_zero),
        .done        (done),
        .zero_flag   (zero_flag),
        .err_div0    (err_div0),
        .err_illegal (err_illegal),
        .err_clr     (err_clr),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // External combinational ALU
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] f);
        case (f)
            ADD:  return a + b;
            SUB:  return a - b;
            MUL:  return a * b;
            DIV:  return (b == 32'd0) ? 32'd0 : a / b;
            MOD:  return (b == 32'd0) ? 32'd0 : a % b;
            AND_: return a & b;
            OR_:  return a | b;
            XOR_: return a ^ b;
            NOT_: return ~a;
            SHL:  return a << b;
            SHR:  return a >> b;
            SLT:  return {31'd0, $signed(a) < $signed(b)};
            SLTU: return {31'd0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res  = alu_model(alu_a, alu_b, alu_func);
    assign alu_zero = (alu_res == 32'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_acc = 0;
    bit          pend     = 0;
    exp_t        pe;
    exp_t        sb[$];
    logic [31:0] mreg [8];
    logic        mzero, mdiv, mill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial forever @(posedge clk) cyc++;

    // Completion monitor: pops the scoreboard on done, checks flags a cycle later
    initial forever begin
        @(negedge clk);
        if (pend) begin
            check("zero_flag", 32'(zero_flag), 32'(pe.zf));
            check("err_div0", 32'(err_div0), 32'(pe.ediv));
            check("err_illegal", 32'(err_illegal), 32'(pe.eill));
            pend = 0;
        end
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                pe = sb.pop_front();
                check("done_latency", 32'(cyc + 1 - pe.acc), 32'd3);
                pend = 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = 32'd0;
        mzero = 1'b0;
        mdiv  = 1'b0;
        mill  = 1'b0;
    endtask

    // Drives a command now and returns 1 time unit after the accepting edge
    task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic ui, input logic [31:0] imm,
                        input bit hold);
        logic [31:0] a, b, r;
        logic        fdiv, fill;
        int          n;
        exp_t        e;
        cmd.valid = 1'b1; cmd.op = op; cmd.rd = rd; cmd.rs1 = rs1;
        cmd.rs2 = rs2; cmd.use_imm = ui; cmd.imm = imm;
        n = 0;
        while (!cmd.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd.ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            cmd.valid = 1'b0;
            return;
        end
        a = mreg[rs1];
        b = ui ? imm : mreg[rs2];
        @(posedge clk);
        #1;
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_func", 32'(alu_func), 32'(op));
        check("ready_low", 32'(cmd.ready), 32'd0);
        r    = alu_model(a, b, op);
        fdiv = ((op == DIV) || (op == MOD)) && (b == 32'd0);
        fill = (op > SLTU);
        if (!(fdiv || fill)) begin
            mzero = (r == 32'd0);
            if (rd != 3'd0) mreg[rd] = r;
        end
        mdiv = mdiv | fdiv;
        mill = mill | fill;
        e.rd = rd; e.zf = mzero; e.ediv = mdiv; e.eill = mill; e.acc = cyc;
        sb.push_back(e);
        last_acc = cyc;
        if (!hold) cmd.valid = 1'b0;
    endtask

    // Waits until the sequencer is idle with nothing outstanding; ends on a negedge
    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cmd.ready && sb.size() == 0 && !pend) && n < 40);
        if (n >= 40) check("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reg(input int i, input logic [31:0] exp);
        dbg_addr = 3'(i);
        #1;
        check($sformatf("R%0d", i), dbg_data, exp);
    endtask

    task automatic check_regs();
        for (int i = 0; i < 8; i++) check_reg(i, mreg[i]);
    endtask

    initial begin
        int a1, a2, a3, n, rel;
        rst = 1'b1; err_clr = 1'b0; dbg_addr = 3'd0;
        cmd.valid = 1'b0; cmd.op = 4'd0; cmd.rd = 3'd0; cmd.rs1 = 3'd0;
        cmd.rs2 = 3'd0; cmd.use_imm = 1'b0; cmd.imm = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ready", 32'(cmd.ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_zero_flag", 32'(zero_flag), 32'd0);
        check("rst_err_div0", 32'(err_div0), 32'd0);
        check("rst_err_illegal", 32'(err_illegal), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_func", 32'(alu_func), 32'd0);
        for (int i = 0; i < 8; i++) check_reg(i, 32'd0);

        // Immediate adds
        @(negedge clk);
        send(ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5, 0);
        wait_idle();
        send(ADD, 3'd2, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF, 0);
        wait_idle();
        check_reg(1, 32'd5);
        check_reg(2, 32'hFFFF_FFFF);

        // SUB to zero, signed and unsigned compares
        send(SUB, 3'd3, 3'd1, 3'd1, 1'b0, 32'd0, 0);
        wait_idle();
        check_reg(3, 32'd0);
        check("sub_zero_flag", 32'(zero_flag), 32'd1);
        send(SLT, 3'd4, 3'd2, 3'd1, 1'b0, 32'd0, 0);
        wait_idle();
        check_reg(4, 32'd1);
        check("slt_zero_flag", 32'(zero_flag), 32'd0);
        send(SLTU, 3'd5, 3'd2, 3'd1, 1'b0, 32'd0, 0);
        wait_idle();
        check_reg(5, 32'd0);

        // Divide by zero, err_clr colliding with a set, then err_clr alone
        send(DIV, 3'd6, 3'd1, 3'd0, 1'b1, 32'd0, 0);
        wait_idle();
        check_reg(6, 32'd0);
        check("div0_set", 32'(err_div0), 32'd1);
        check("div0_zf_kept", 32'(zero_flag), 32'd1);
        send(DIV, 3'd6, 3'd1, 3'd0, 1'b1, 32'd0, 0);
        n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("div0_done_seen", 32'(done), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("div0_set_wins", 32'(err_div0), 32'd1);
        wait_idle();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        mdiv = 1'b0;
        check("div0_cleared", 32'(err_div0), 32'd0);

        // Illegal opcode, then write to r0
        send(4'hF, 3'd5, 3'd1, 3'd0, 1'b1, 32'd1, 0);
        wait_idle();
        check("illegal_set", 32'(err_illegal), 32'd1);
        check_regs();
        send(ADD, 3'd0, 3'd1, 3'd0, 1'b1, 32'd7, 0);
        wait_idle();
        check_reg(0, 32'd0);

        // Dependency chain with valid held high throughout
        send(ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd3, 1);
        a1 = last_acc;
        send(SHL, 3'd1, 3'd1, 3'd0, 1'b1, 32'd2, 1);
        a2 = last_acc;
        send(MOD, 3'd1, 3'd1, 3'd0, 1'b1, 32'd5, 0);
        a3 = last_acc;
        check("chain_gap1", 32'(a2 - a1), 32'd4);
        check("chain_gap2", 32'(a3 - a2), 32'd4);
        wait_idle();
        check_reg(1, 32'd2);

        // NOT and a handful of random commands
        send(NOT_, 3'd7, 3'd1, 3'd3, 1'b0, 32'd0, 0);
        wait_idle();
        check_reg(7, 32'hFFFF_FFFD);
        for (int k = 0; k < 8; k++) begin
            send(4'($urandom_range(12, 0)), 3'($urandom_range(7, 1)), 3'($urandom_range(7, 0)),
                 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
                 (k % 2 == 0) ? 32'($urandom_range(40, 0)) : $urandom, 0);
            wait_idle();
        end
        check_regs();

        // Reset during CAPT aborts the command
        send(MUL, 3'd7, 3'd1, 3'd1, 1'b0, 32'd0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        model_reset();
        #1;
        check("abort_ready", 32'(cmd.ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        send(ADD, 3'd3, 3'd0, 3'd0, 1'b1, 32'd9, 0);
        check("first_after_rst", 32'(last_acc - rel), 32'd1);
        wait_idle();
        check_reg(7, 32'd0);
        check_reg(3, 32'd9);
        check_regs();
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) n++;
        end
        check("no_spurious_done", 32'(n), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
